// File: rtl/fmac_credit_stats_sched_pkg.sv
// Shared types and constants for the FMAC credit-stats interval scheduler.
package fmac_credit_stats_sched_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, SEND} sched_state_t;

  typedef enum logic [1:0] {SEL_MINCR, SEL_MAXCR, SEL_ENDCR, SEL_TIMECR} word_sel_t;

  localparam int WORDS_PER_CH = 4;

endpackage

// File: rtl/fmac_stats_interval_timer.sv
// Periodic interval timer: enable-edge load, down-count, reload on expiry,
// merged with the software latch-now request into a single-cycle tick.
module fmac_stats_interval_timer
  import fmac_credit_stats_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] period,
  input  logic        latch_now,
  output logic        tick
);

  logic        en_q;
  logic [31:0] cnt;
  logic        fire;

  assign fire = en && (cnt == 32'd1);
  assign tick = fire || latch_now;

  // A latch_now reload keeps the next periodic tick a full period away.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q <= 1'b0;
      cnt  <= '0;
    end else begin
      en_q <= en;
      if (!en) begin
        cnt <= '0;
      end else if (!en_q || tick) begin
        cnt <= period;
      end else if (cnt != 32'd0) begin
        cnt <= cnt - 32'd1;
      end
    end
  end

endmodule

// File: rtl/fmac_credit_stats_sched.sv
// Credit-stats interval scheduler: pulses latch_clr, snapshots all channels
// after the counters settle, and streams the snapshot over valid/ready.
//
//   state   | meaning
//   IDLE    | waiting for a tick
//   WAIT    | letting channel counters settle after latch_clr
//   CAPTURE | copy all channel stats into the shadow bank
//   SEND    | stream shadow words, ch-major / sel-minor
module fmac_credit_stats_sched
  import fmac_credit_stats_sched_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int LATCH_DLY = 2,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reg_interval_en,
  input  logic [31:0]          reg_interval_period,
  input  logic                 reg_latch_now,
  input  logic [NUM_CH*32-1:0] ch_mincr,
  input  logic [NUM_CH*32-1:0] ch_maxcr,
  input  logic [NUM_CH*32-1:0] ch_endcr,
  input  logic [NUM_CH*32-1:0] ch_timecr,
  output logic                 int_stats_latch_clr,
  output logic                 stats_vld,
  input  logic                 stats_rdy,
  output logic [CH_W-1:0]      stats_ch,
  output logic [1:0]           stats_sel,
  output logic [31:0]          stats_data,
  output logic                 stats_last,
  output logic                 sched_busy,
  output logic [15:0]          overrun_cnt
);

  logic            tick;
  sched_state_t    state;
  logic [2:0]      wait_cnt;
  logic [CH_W-1:0] ch_q;
  logic [1:0]      sel_q;
  logic [CH_W-1:0] ch_nxt;
  logic [1:0]      sel_nxt;
  logic            last_nxt;
  logic [31:0]     shadow [NUM_CH][WORDS_PER_CH];

  fmac_stats_interval_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .en        (reg_interval_en),
    .period    (reg_interval_period),
    .latch_now (reg_latch_now),
    .tick      (tick)
  );

  always_comb begin
    sel_nxt  = sel_q + 2'd1;
    ch_nxt   = (sel_q == 2'd3) ? ch_q + CH_W'(1) : ch_q;
    last_nxt = (ch_nxt == CH_W'(NUM_CH - 1)) && (sel_nxt == 2'd3);
  end

  assign stats_ch  = ch_q;
  assign stats_sel = sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      wait_cnt            <= '0;
      ch_q                <= '0;
      sel_q               <= '0;
      stats_vld           <= 1'b0;
      stats_data          <= '0;
      stats_last          <= 1'b0;
      sched_busy          <= 1'b0;
      overrun_cnt         <= '0;
      int_stats_latch_clr <= 1'b0;
      for (int c = 0; c < NUM_CH; c++)
        for (int s = 0; s < WORDS_PER_CH; s++)
          shadow[c][s] <= '0;
    end else begin
      int_stats_latch_clr <= tick;
      // Interval still closes on overrun; only its snapshot is lost.
      if (tick && (state != IDLE) && (overrun_cnt != 16'hFFFF))
        overrun_cnt <= overrun_cnt + 16'd1;

      case (state)
        IDLE: begin
          if (tick) begin
            state      <= WAIT;
            wait_cnt   <= 3'(LATCH_DLY);
            sched_busy <= 1'b1;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1)
            state <= CAPTURE;
        end
        CAPTURE: begin
          for (int c = 0; c < NUM_CH; c++) begin
            shadow[c][SEL_MINCR]  <= ch_mincr[32*c +: 32];
            shadow[c][SEL_MAXCR]  <= ch_maxcr[32*c +: 32];
            shadow[c][SEL_ENDCR]  <= ch_endcr[32*c +: 32];
            shadow[c][SEL_TIMECR] <= ch_timecr[32*c +: 32];
          end
          ch_q       <= '0;
          sel_q      <= '0;
          stats_data <= ch_mincr[31:0];
          stats_last <= 1'b0;
          stats_vld  <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (stats_rdy) begin
            if (stats_last) begin
              state      <= IDLE;
              stats_vld  <= 1'b0;
              stats_last <= 1'b0;
              sched_busy <= 1'b0;
              ch_q       <= '0;
              sel_q      <= '0;
            end else begin
              ch_q       <= ch_nxt;
              sel_q      <= sel_nxt;
              stats_data <= shadow[ch_nxt][sel_nxt];
              stats_last <= last_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmac_credit_stats_sched.sv
// Bench for fmac_credit_stats_sched: cycle-level behavioural model plus
// directed scenarios with literal expectations.
module tb_fmac_credit_stats_sched;

  localparam int NUM_CH    = 4;
  localparam int LATCH_DLY = 2;
  localparam int NW        = NUM_CH * 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 reg_interval_en = 1'b0;
  logic [31:0]          reg_interval_period = '0;
  logic                 reg_latch_now = 1'b0;
  logic                 stats_rdy = 1'b0;
  logic [NUM_CH*32-1:0] ch_mincr, ch_maxcr, ch_endcr, ch_timecr;
  logic                 int_stats_latch_clr, stats_vld, stats_last, sched_busy;
  logic [1:0]           stats_ch, stats_sel;
  logic [31:0]          stats_data;
  logic [15:0]          overrun_cnt;

  fmac_credit_stats_sched #(.NUM_CH(NUM_CH), .LATCH_DLY(LATCH_DLY)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .reg_interval_en     (reg_interval_en),
    .reg_interval_period (reg_interval_period),
    .reg_latch_now       (reg_latch_now),
    .ch_mincr            (ch_mincr),
    .ch_maxcr            (ch_maxcr),
    .ch_endcr            (ch_endcr),
    .ch_timecr           (ch_timecr),
    .int_stats_latch_clr (int_stats_latch_clr),
    .stats_vld           (stats_vld),
    .stats_rdy           (stats_rdy),
    .stats_ch            (stats_ch),
    .stats_sel           (stats_sel),
    .stats_data          (stats_data),
    .stats_last          (stats_last),
    .sched_busy          (sched_busy),
    .overrun_cnt         (overrun_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] in_word(input int c, input int s);
    case (s)
      0:       return ch_mincr[32*c +: 32];
      1:       return ch_maxcr[32*c +: 32];
      2:       return ch_endcr[32*c +: 32];
      default: return ch_timecr[32*c +: 32];
    endcase
  endfunction

  // Model: absolute next-tick cycle for the timer, a snapshot array and a
  // word pointer for the sweep.
  longint      next_tick = -1;
  logic        en_prev = 1'b0;
  logic        m_latch = 1'b0;
  int          m_ovr = 0;
  logic        m_busy = 1'b0;
  logic        m_vld = 1'b0;
  int          m_idx = 0;
  longint      m_t = 0;
  logic [31:0] snap [NW];
  logic        armed = 1'b0;

  always @(negedge clk) begin
    logic   tk;
    longint n;
    n = cyc;
    if (armed) begin
      chk("latch_clr", int_stats_latch_clr, m_latch);
      chk("busy", sched_busy, m_busy);
      chk("vld", stats_vld, m_vld);
      chk("overrun_cnt", overrun_cnt, m_ovr);
      if (m_vld) begin
        chk("ch", stats_ch, m_idx / 4);
        chk("sel", stats_sel, m_idx % 4);
        chk("data", stats_data, snap[m_idx]);
        chk("last", stats_last, (m_idx == NW - 1));
      end
    end
    if (rst) begin
      armed = 1'b1; next_tick = -1; en_prev = 1'b0; m_latch = 1'b0;
      m_ovr = 0; m_busy = 1'b0; m_vld = 1'b0; m_idx = 0;
    end else begin
      tk = reg_latch_now || (reg_interval_en && (next_tick == n));
      if (!reg_interval_en)
        next_tick = -1;
      else if (!en_prev || tk)
        next_tick = (reg_interval_period == 0) ? -1 : n + longint'(reg_interval_period);
      en_prev = reg_interval_en;
      if (tk && m_busy && m_ovr < 65535) m_ovr++;
      if (m_busy) begin
        if (m_vld) begin
          if (stats_rdy) begin
            if (m_idx == NW - 1) begin
              m_busy = 1'b0; m_vld = 1'b0; m_idx = 0;
            end else begin
              m_idx++;
            end
          end
        end else if (n == m_t + LATCH_DLY) begin
          for (int w = 0; w < NW; w++) snap[w] = in_word(w / 4, w % 4);
          m_vld = 1'b1; m_idx = 0;
        end
      end else if (tk) begin
        m_busy = 1'b1; m_t = n + 1;
      end
      m_latch = tk;
    end
  end

  // Event recorders used by the literal expectations.
  int          latch_q [$];
  int          vrise_q [$];
  logic [31:0] words [$];
  int          nlast = 0;
  logic        vprev = 1'b0;
  always @(negedge clk) begin
    if (int_stats_latch_clr === 1'b1) latch_q.push_back(cyc);
    if (stats_vld === 1'b1 && vprev !== 1'b1) vrise_q.push_back(cyc);
    vprev = stats_vld;
    if (stats_vld === 1'b1 && stats_rdy === 1'b1) begin
      words.push_back(stats_data);
      if (stats_last === 1'b1) nlast++;
    end
  end

  logic scramble = 1'b0;
  logic rdy_rand = 1'b0;

  task automatic set_pattern();
    for (int c = 0; c < NUM_CH; c++) begin
      ch_mincr[32*c +: 32]  = 32'hC0 + c;
      ch_maxcr[32*c +: 32]  = 32'hC4 + c;
      ch_endcr[32*c +: 32]  = 32'hC8 + c;
      ch_timecr[32*c +: 32] = 32'hCC + c;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (scramble)
      for (int c = 0; c < NUM_CH; c++) begin
        ch_mincr[32*c +: 32]  = $urandom;
        ch_maxcr[32*c +: 32]  = $urandom;
        ch_endcr[32*c +: 32]  = $urandom;
        ch_timecr[32*c +: 32] = $urandom;
      end
    if (rdy_rand) stats_rdy = ($urandom_range(0, 99) < 30);
  endtask

  task automatic steps(input int k);
    repeat (k) step();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    i = 0;
    while (sched_busy !== 1'b0 && i < budget) begin
      step();
      i++;
    end
    chk(name, sched_busy, 1'b0);
  endtask

  initial begin
    int c0, l0, w0, v0, n0;
    logic found;
    set_pattern();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_vld", stats_vld, 0);
    chk("rst_busy", sched_busy, 0);
    chk("rst_latch", int_stats_latch_clr, 0);
    chk("rst_ovr", overrun_cnt, 0);
    chk("rst_data", stats_data, 0);
    chk("rst_last", stats_last, 0);
    chk("rst_ch", stats_ch, 0);
    chk("rst_sel", stats_sel, 0);

    // Periodic timer, period 100, full-speed consumer.
    stats_rdy = 1'b1;
    step();
    reg_interval_period = 100;
    reg_interval_en = 1'b1;
    c0 = cyc; l0 = latch_q.size(); w0 = words.size(); v0 = vrise_q.size(); n0 = nlast;
    steps(320);
    reg_interval_en = 1'b0;
    chk("t100_pulses", latch_q.size() - l0, 3);
    if (latch_q.size() >= l0 + 3) begin
      chk("t100_first", latch_q[l0] - c0, 101);
      chk("t100_second", latch_q[l0+1] - c0, 201);
      chk("t100_third", latch_q[l0+2] - c0, 301);
    end
    if (vrise_q.size() > v0 && latch_q.size() > l0)
      chk("vld_latency", vrise_q[v0] - latch_q[l0], LATCH_DLY + 1);
    chk("t100_words", words.size() - w0, 3 * NW);
    chk("t100_lasts", nlast - n0, 3);
    if (words.size() >= w0 + NW) begin
      chk("word0", words[w0], 32'hC0);
      chk("word1", words[w0+1], 32'hC4);
      chk("word4", words[w0+4], 32'hC1);
      chk("word14", words[w0+14], 32'hCB);
      chk("word15", words[w0+15], 32'hCF);
    end
    steps(20);

    // Period 0 never fires.
    reg_interval_period = 0;
    reg_interval_en = 1'b1;
    l0 = latch_q.size();
    steps(1000);
    reg_interval_en = 1'b0;
    chk("p0_pulses", latch_q.size() - l0, 0);
    steps(5);

    // latch_now with timer disabled, random backpressure, inputs churning after capture.
    rdy_rand = 1'b1;
    w0 = words.size(); l0 = latch_q.size();
    reg_latch_now = 1'b1;
    step();
    reg_latch_now = 1'b0;
    steps(3);
    scramble = 1'b1;
    wait_idle("bp_timeout", 400);
    chk("bp_pulses", latch_q.size() - l0, 1);
    chk("bp_words", words.size() - w0, NW);
    if (words.size() >= w0 + NW) begin
      chk("bp_word0", words[w0], 32'hC0);
      chk("bp_word15", words[w0+15], 32'hCF);
    end
    rdy_rand = 1'b0;
    stats_rdy = 1'b1;
    steps(5);

    // Overrun: period 10 with consumer stalled.
    stats_rdy = 1'b0;
    step();
    reg_interval_period = 10;
    reg_interval_en = 1'b1;
    l0 = latch_q.size();
    steps(55);
    reg_interval_en = 1'b0;
    chk("ovr_pulses", latch_q.size() - l0, 5);
    chk("ovr_cnt4", overrun_cnt, 4);
    stats_rdy = 1'b1;
    wait_idle("ovr_timeout", 100);
    steps(5);

    // latch_now coincident with a timer expiry.
    reg_interval_period = 20;
    reg_interval_en = 1'b1;
    c0 = cyc; l0 = latch_q.size();
    steps(20);
    reg_latch_now = 1'b1;
    step();
    reg_latch_now = 1'b0;
    steps(4);
    reg_interval_en = 1'b0;
    chk("coinc_pulses", latch_q.size() - l0, 1);
    if (latch_q.size() > l0) chk("coinc_cycle", latch_q[l0] - c0, 21);
    wait_idle("coinc_timeout", 100);
    steps(5);

    // Saturation: tick every cycle with consumer stalled.
    stats_rdy = 1'b0;
    reg_interval_period = 1;
    reg_interval_en = 1'b1;
    steps(65560);
    chk("ovr_sat", overrun_cnt, 16'hFFFF);
    reg_interval_en = 1'b0;
    stats_rdy = 1'b1;
    wait_idle("sat_timeout", 100);
    chk("ovr_sat_hold", overrun_cnt, 16'hFFFF);
    steps(5);

    // Reset in the middle of a sweep, at word 5.
    reg_latch_now = 1'b1;
    step();
    reg_latch_now = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (stats_vld === 1'b1 && stats_ch == 2'd1 && stats_sel == 2'd1) found = 1'b1;
    end
    chk("rst_word5_reached", found, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_vld", stats_vld, 0);
    chk("mid_rst_busy", sched_busy, 0);
    chk("mid_rst_ovr", overrun_cnt, 0);
    chk("mid_rst_latch", int_stats_latch_clr, 0);
    v0 = vrise_q.size(); n0 = nlast;
    steps(50);
    chk("post_rst_vld_rises", vrise_q.size() - v0, 0);
    chk("post_rst_lasts", nlast - n0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
